// File: rtl/aclk_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_keypad_scanner
//  Description : 4x4 active-low matrix keypad scanner with debounce, key-code
//                decode, 4-digit BCD key buffer and command-key strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module aclk_keypad_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] key_ms_hr,
  output logic [3:0] key_ls_hr,
  output logic [3:0] key_ms_min,
  output logic [3:0] key_ls_min,
  output logic       alarm_button,
  output logic       time_button
);

  localparam int c_STEP_W = $clog2(SCAN_DIV);
  localparam int c_CNT_W  = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(SCAN_DIV - 1);
  localparam logic [c_STEP_W-1:0] c_STEP_ONE  = c_STEP_W'(1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0]  c_DEB_TGT   = c_CNT_W'(DEBOUNCE_CNT);

  localparam logic [1:0] c_ST_SCAN     = 2'd0;
  localparam logic [1:0] c_ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] c_ST_RELEASE  = 2'd2;

  logic [3:0]          r_col_meta, r_col_sync;
  logic [c_STEP_W-1:0] r_step;
  logic [1:0]          r_state, w_state_nxt;
  logic [1:0]          r_row_idx, w_row_idx_nxt;
  logic [1:0]          r_col_idx, w_col_idx_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [3:0]          r_row_n;
  logic                w_sample;
  logic [3:0]          w_col_low;
  logic                w_col_one;
  logic [1:0]          w_col_hit;
  logic                w_accept;
  logic [3:0]          w_key_code;
  logic [15:0]         r_buf, w_buf_nxt;
  logic                r_key_valid, r_alarm, r_time;
  logic [3:0]          r_key_code;

  function automatic logic [3:0] f_key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  assign w_sample  = (r_step == c_STEP_LAST);
  assign w_col_low = ~r_col_sync;
  assign w_cnt_inc = r_cnt + c_CNT_ONE;

  // A press counts only when exactly one column is pulled low.
  always_comb begin
    w_col_one = 1'b1;
    w_col_hit = 2'd0;
    case (w_col_low)
      4'b0001: w_col_hit = 2'd0;
      4'b0010: w_col_hit = 2'd1;
      4'b0100: w_col_hit = 2'd2;
      4'b1000: w_col_hit = 2'd3;
      default: w_col_one = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_meta <= 4'hF;
      r_col_sync <= 4'hF;
      r_step     <= '0;
      r_state    <= c_ST_SCAN;
      r_row_idx  <= 2'd0;
      r_col_idx  <= 2'd0;
      r_cnt      <= '0;
      r_row_n    <= 4'b1110;
    end else begin
      r_col_meta <= col_n;
      r_col_sync <= r_col_meta;
      r_step     <= w_sample ? '0 : r_step + c_STEP_ONE;
      r_state    <= w_state_nxt;
      r_row_idx  <= w_row_idx_nxt;
      r_col_idx  <= w_col_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_row_n    <= ~(4'b0001 << w_row_idx_nxt);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    w_col_idx_nxt = r_col_idx;
    w_cnt_nxt     = r_cnt;
    if (w_sample) begin
      case (r_state)
        c_ST_SCAN: begin
          if (w_col_one) begin
            w_col_idx_nxt = w_col_hit;
            if (w_accept) begin
              w_state_nxt = c_ST_RELEASE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = c_ST_DEBOUNCE;
              w_cnt_nxt   = c_CNT_ONE;
            end
          end else begin
            w_row_idx_nxt = r_row_idx + 2'd1;
          end
        end
        c_ST_DEBOUNCE: begin
          if (w_col_one && (w_col_hit == r_col_idx)) begin
            if (w_accept) begin
              w_state_nxt = c_ST_RELEASE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt   = c_ST_SCAN;
            w_row_idx_nxt = r_row_idx + 2'd1;
            w_cnt_nxt     = '0;
          end
        end
        c_ST_RELEASE: begin
          if (r_col_sync == 4'hF) begin
            if (w_cnt_inc == c_DEB_TGT) begin
              w_state_nxt   = c_ST_SCAN;
              w_row_idx_nxt = r_row_idx + 2'd1;
              w_cnt_nxt     = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = c_ST_SCAN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // With a debounce target of one the entering sample is already the accept.
  always_comb begin
    w_accept   = 1'b0;
    w_key_code = f_key_map(r_row_idx, w_col_hit);
    w_buf_nxt  = r_buf;
    if (w_sample && w_col_one) begin
      if (r_state == c_ST_SCAN)
        w_accept = (c_DEB_TGT == c_CNT_ONE);
      else if (r_state == c_ST_DEBOUNCE)
        w_accept = (w_col_hit == r_col_idx) && (w_cnt_inc == c_DEB_TGT);
    end
    if (w_accept) begin
      if (w_key_code <= 4'd9)
        w_buf_nxt = {r_buf[11:0], w_key_code};
      else if (w_key_code == 4'hC)
        w_buf_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_key_valid <= 1'b0;
      r_alarm     <= 1'b0;
      r_time      <= 1'b0;
      r_key_code  <= 4'hF;
      r_buf       <= '0;
    end else begin
      r_key_valid <= w_accept;
      r_alarm     <= w_accept && (w_key_code == 4'hA);
      r_time      <= w_accept && (w_key_code == 4'hB);
      if (w_accept)
        r_key_code <= w_key_code;
      r_buf <= w_buf_nxt;
    end
  end

  assign row_n        = r_row_n;
  assign key_valid    = r_key_valid;
  assign key_code     = r_key_code;
  assign key_ms_hr    = r_buf[15:12];
  assign key_ls_hr    = r_buf[11:8];
  assign key_ms_min   = r_buf[7:4];
  assign key_ls_min   = r_buf[3:0];
  assign alarm_button = r_alarm;
  assign time_button  = r_time;

endmodule
`default_nettype wire

// File: tb/tb_aclk_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aclk_keypad_scanner
//  Description : Directed bench for aclk_keypad_scanner with a sample-level
//                keypad model and per-cycle output comparison.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aclk_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] row_n, col_n;
  logic       key_valid, alarm_button, time_button;
  logic [3:0] key_code, key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic [15:0] pressed = '0;

  int checks = 0, errors = 0;
  int n_valid = 0, n_alarm = 0, n_time = 0;
  bit chk_en = 1'b0;

  aclk_keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk(clk), .reset_n(reset_n), .row_n(row_n), .col_n(col_n),
    .key_valid(key_valid), .key_code(key_code),
    .key_ms_hr(key_ms_hr), .key_ls_hr(key_ls_hr),
    .key_ms_min(key_ms_min), .key_ls_min(key_ls_min),
    .alarm_button(alarm_button), .time_button(time_button)
  );

  always #5 clk = ~clk;

  // Keypad: a pressed key shorts its column low while its row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row_n[r])
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c]) col_n[c] = 1'b0;
  end

  // Sample-level model: buffer held as a decimal number, row as an index.
  int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  int m_r = 0, m_step = 0, m_cand = -1, m_run = 0, m_quiet = 0, m_buf = 0, m_code = 15;
  bit m_locked = 0, m_valid = 0, m_alarm = 0, m_time = 0;
  logic [3:0] m_hist0 = 4'hF, m_hist1 = 4'hF;

  function automatic int single_col(input logic [3:0] s);
    int n, c;
    n = 0; c = -1;
    for (int i = 0; i < 4; i++) if (!s[i]) begin n++; c = i; end
    return (n == 1) ? c : -1;
  endfunction

  task automatic model_accept(input int k);
    m_valid = 1; m_code = k;
    if (k < 10) m_buf = (m_buf % 1000) * 10 + k;
    else if (k == 10) m_alarm = 1;
    else if (k == 11) m_time = 1;
    else if (k == 12) m_buf = 0;
  endtask

  task automatic model_sample(input logic [3:0] s);
    int c;
    c = single_col(s);
    if (m_locked) begin
      m_quiet = (s == 4'hF) ? m_quiet + 1 : 0;
      if (m_quiet == DEB) begin m_locked = 0; m_quiet = 0; m_r = (m_r + 1) % 4; end
    end else begin
      if (m_cand < 0) begin
        if (c >= 0) begin m_cand = c; m_run = 1; end
        else m_r = (m_r + 1) % 4;
      end else if (c == m_cand) begin
        m_run++;
      end else begin
        m_cand = -1; m_r = (m_r + 1) % 4;
      end
      if (m_cand >= 0 && m_run == DEB) begin
        model_accept(keymap[m_r][m_cand]);
        m_cand = -1; m_locked = 1; m_quiet = 0;
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_r = 0; m_step = 0; m_cand = -1; m_run = 0; m_quiet = 0; m_buf = 0; m_code = 15;
      m_locked = 0; m_valid = 0; m_alarm = 0; m_time = 0; m_hist0 = 4'hF; m_hist1 = 4'hF;
    end else begin
      m_valid = 0; m_alarm = 0; m_time = 0;
      if (m_step == SCAN_DIV - 1) model_sample(m_hist1);
      m_step = (m_step + 1) % SCAN_DIV;
      m_hist1 = m_hist0;
      m_hist0 = col_n;
    end
  end

  always @(negedge clk) begin
    logic [26:0] got, exp;
    logic [3:0]  er;
    if (chk_en) begin
      er = 4'hF; er[m_r] = 1'b0;
      got = {row_n, key_valid, key_code, key_ms_hr, key_ls_hr, key_ms_min, key_ls_min,
             alarm_button, time_button};
      exp = {er, m_valid, 4'(m_code), 4'(m_buf / 1000), 4'(m_buf / 100 % 10),
             4'(m_buf / 10 % 10), 4'(m_buf % 10), m_alarm, m_time};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL cycle t=%0t got=%h exp=%h (row,valid,code,digits,alarm,time)", $time, got, exp);
      end
      if (key_valid) n_valid++;
      if (alarm_button) n_alarm++;
      if (time_button) n_time++;
    end
  end

  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input int r, input int c, input int hold);
    pressed = 16'(1 << (r*4 + c));
    cycles(hold);
    pressed = '0;
    cycles(60);
  endtask

  function automatic int buf_now();
    return {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};
  endfunction

  initial begin
    int v0;
    cycles(3);
    chk_en = 1'b1;
    check_lit("reset_row", row_n, 4'hE);
    check_lit("reset_code", key_code, 4'hF);
    check_lit("reset_buf", buf_now(), 16'h0000);
    reset_n = 1'b1;
    cycles(30);
    #2 reset_n = 1'b0;
    cycles(2);
    check_lit("midrun_reset_row", row_n, 4'hE);
    check_lit("midrun_reset_strobes", {key_valid, alarm_button, time_button}, 0);
    reset_n = 1'b1;
    cycles(3);
    check_lit("row_hold0", row_n, 4'hE);
    cycles(1);
    check_lit("row_step1", row_n, 4'hD);
    cycles(4);
    check_lit("row_step2", row_n, 4'hB);
    cycles(4);
    check_lit("row_step3", row_n, 4'h7);
    cycles(4);
    check_lit("row_wrap", row_n, 4'hE);

    v0 = n_valid;
    press_key(0, 0, 100); press_key(0, 1, 100); press_key(0, 2, 100); press_key(1, 0, 100);
    check_lit("digit_strobes", n_valid - v0, 4);
    check_lit("buf_1234", buf_now(), 16'h1234);
    press_key(1, 1, 100);
    check_lit("buf_2345", buf_now(), 16'h2345);

    v0 = n_valid;
    for (int i = 0; i < 4; i++) begin
      pressed = 16'(1 << 8);
      cycles(8);
      pressed = '0;
      cycles(8);
    end
    check_lit("bounce_no_strobe", n_valid - v0, 0);
    press_key(2, 0, 100);
    check_lit("bounce_one_strobe", n_valid - v0, 1);
    check_lit("bounce_code", key_code, 4'h7);

    v0 = n_valid;
    press_key(3, 1, 200);
    check_lit("hold_one_strobe", n_valid - v0, 1);
    check_lit("hold_ls_min", key_ls_min, 0);

    press_key(2, 3, 100);
    check_lit("clear_buf", buf_now(), 16'h0000);
    press_key(0, 0, 100); press_key(0, 1, 100); press_key(0, 2, 100); press_key(1, 0, 100);
    v0 = n_alarm;
    press_key(0, 3, 100);
    check_lit("alarm_strobe", n_alarm - v0, 1);
    check_lit("alarm_buf", buf_now(), 16'h1234);
    check_lit("alarm_code", key_code, 4'hA);
    v0 = n_time;
    press_key(1, 3, 100);
    check_lit("time_strobe", n_time - v0, 1);
    check_lit("time_buf", buf_now(), 16'h1234);
    check_lit("time_code", key_code, 4'hB);
    press_key(2, 3, 100);
    check_lit("cmd_clear_buf", buf_now(), 16'h0000);
    check_lit("cmd_clear_code", key_code, 4'hC);

    v0 = n_valid;
    pressed = 16'b0011;
    cycles(100);
    pressed = '0;
    cycles(60);
    check_lit("multikey_no_strobe", n_valid - v0, 0);

    press_key(1, 1, 100);
    check_lit("pre_abort_buf", buf_now(), 16'h0005);
    v0 = n_valid;
    pressed = 16'(1 << 10);
    for (int i = 0; i < 200 && m_cand < 0; i++) @(negedge clk);
    if (m_cand < 0) begin
      checks++; errors++;
      $display("FAIL abort_reach_debounce got=none exp=debounce");
    end
    #2 reset_n = 1'b0;
    cycles(3);
    check_lit("abort_no_strobe", n_valid - v0, 0);
    check_lit("abort_buf", buf_now(), 16'h0000);
    check_lit("abort_code", key_code, 4'hF);
    check_lit("abort_row", row_n, 4'hE);
    pressed = '0;
    reset_n = 1'b1;
    cycles(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
